// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// ---------------------------------------------------------------------------
// Main control unit for the multicycle MIPS datapath. Each instruction walks
// through fetch, decode and then an opcode-specific chain of execute, memory
// and writeback states, one state per clock. Every datapath mux select and
// write enable is decoded combinationally from the current state. The ALU
// decoder that turns aluop/funct into the 3-bit ALU operation lives here too.
//
// Parameters:
//   ILLEGAL_TRAP  0: unknown opcode goes back to FETCH after DECODE
//                 1: unknown opcode parks the FSM in HALT until reset
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   op[5:0]      in   instr[31:26] from the instruction register
//   funct[5:0]   in   instr[5:0] from the instruction register
//   zero         in   ALU zero flag
//   irwrite      out  instruction register load
//   pcen         out  PC load = pcwrite | (branch & zero)
//   iord         out  memory address select (0 PC, 1 ALUOut)
//   memwrite     out  data memory write
//   regdst       out  write register select (0 rt, 1 rd)
//   memtoreg     out  writeback data select (0 ALUOut, 1 memory data)
//   regwrite     out  register file write
//   alusrca      out  ALU A select (0 PC, 1 register A)
//   alusrcb[1:0] out  ALU B select (00 B, 01 4, 10 imm, 11 imm<<2)
//   pcsrc[1:0]   out  PC source (00 ALU result, 01 ALUOut, 10 jump target)
//   alu_control  out  ALU op (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
//   instr_done   out  high in the final state of each instruction
//   halted       out  high while in HALT
// ---------------------------------------------------------------------------
module mc_control_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       irwrite,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alu_control,
  output logic       instr_done,
  output logic       halted
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    HALT    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  state_e state_q, state_d;

  // Raw per-state decode; the write enables are gated by reset afterwards.
  logic       irwriteRaw;
  logic       pcwriteRaw;
  logic       branchRaw;
  logic       memwriteRaw;
  logic       regwriteRaw;
  logic       instrDoneRaw;
  logic       haltedRaw;
  logic [1:0] aluop;

  // State register. A reset edge always lands in FETCH, even from HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state output decode. Everything defaults to 0 so
  // each state only lists the signals it actually asserts.
  always_comb begin
    state_d      = FETCH;
    irwriteRaw   = 1'b0;
    pcwriteRaw   = 1'b0;
    branchRaw    = 1'b0;
    memwriteRaw  = 1'b0;
    regwriteRaw  = 1'b0;
    instrDoneRaw = 1'b0;
    haltedRaw    = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = ALUOP_ADD;

    case (state_q)
      FETCH: begin
        alusrcb    = 2'b01;
        irwriteRaw = 1'b1;
        pcwriteRaw = 1'b1;
        state_d    = DECODE;
      end
      DECODE: begin
        // ALU computes PC+4 + (imm<<2) now so BRANCH can use ALUOut.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = ILLEGAL_TRAP ? HALT : FETCH;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg     = 1'b1;
        regwriteRaw  = 1'b1;
        instrDoneRaw = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwriteRaw  = 1'b1;
        instrDoneRaw = 1'b1;
        state_d      = FETCH;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = ALUWB;
      end
      ALUWB: begin
        regdst       = 1'b1;
        regwriteRaw  = 1'b1;
        instrDoneRaw = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        alusrca      = 1'b1;
        aluop        = ALUOP_SUB;
        pcsrc        = 2'b01;
        branchRaw    = 1'b1;
        instrDoneRaw = 1'b1;
        state_d      = FETCH;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        regwriteRaw  = 1'b1;
        instrDoneRaw = 1'b1;
        state_d      = FETCH;
      end
      JUMP: begin
        pcsrc        = 2'b10;
        pcwriteRaw   = 1'b1;
        instrDoneRaw = 1'b1;
        state_d      = FETCH;
      end
      HALT: begin
        haltedRaw = 1'b1;
        state_d   = HALT;
      end
      default: begin
        // Unused encodings recover through FETCH.
        state_d = FETCH;
      end
    endcase
  end

  // ALU decoder. Unknown funct codes quietly fall back to ADD.
  always_comb begin
    alu_control = 3'b010;
    case (aluop)
      ALUOP_ADD: alu_control = 3'b010;
      ALUOP_SUB: alu_control = 3'b110;
      default: begin
        case (funct)
          6'b100000: alu_control = 3'b010;
          6'b100010: alu_control = 3'b110;
          6'b100100: alu_control = 3'b000;
          6'b100101: alu_control = 3'b001;
          6'b101010: alu_control = 3'b111;
          default:   alu_control = 3'b010;
        endcase
      end
    endcase
  end

  // While reset is high nothing may be written, so an abandoned
  // instruction cannot leave a partial update behind.
  always_comb begin
    irwrite    = irwriteRaw & ~reset;
    pcen       = (pcwriteRaw | (branchRaw & zero)) & ~reset;
    memwrite   = memwriteRaw & ~reset;
    regwrite   = regwriteRaw & ~reset;
    instr_done = instrDoneRaw & ~reset;
    halted     = haltedRaw & ~reset;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
// ---------------------------------------------------------------------------
// Directed bench for mc_control_fsm. Two instances share all inputs: dut0
// has ILLEGAL_TRAP=0 and dut1 has ILLEGAL_TRAP=1. Each scenario task walks
// an instruction through its states and compares the full output vector
// against a hand-written per-state table.
// ---------------------------------------------------------------------------
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic       irwrite0, pcen0, iord0, memwrite0, regdst0, memtoreg0, regwrite0;
  logic       alusrca0, instrDone0, halted0;
  logic [1:0] alusrcb0, pcsrc0;
  logic [2:0] aluControl0;

  logic       irwrite1, pcen1, iord1, memwrite1, regdst1, memtoreg1, regwrite1;
  logic       alusrca1, instrDone1, halted1;
  logic [1:0] alusrcb1, pcsrc1;
  logic [2:0] aluControl1;

  logic [16:0] obs0, obs1;

  int checkCount = 0;
  int passCount  = 0;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                 S_MEMWB = 4, S_MEMWR = 5, S_EXECUTE = 6, S_ALUWB = 7,
                 S_BRANCH = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11,
                 S_HALT = 12;

  always #5 clk = ~clk;

  mc_control_fsm #(.ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .irwrite(irwrite0), .pcen(pcen0), .iord(iord0), .memwrite(memwrite0),
    .regdst(regdst0), .memtoreg(memtoreg0), .regwrite(regwrite0),
    .alusrca(alusrca0), .alusrcb(alusrcb0), .pcsrc(pcsrc0),
    .alu_control(aluControl0), .instr_done(instrDone0), .halted(halted0)
  );

  mc_control_fsm #(.ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .irwrite(irwrite1), .pcen(pcen1), .iord(iord1), .memwrite(memwrite1),
    .regdst(regdst1), .memtoreg(memtoreg1), .regwrite(regwrite1),
    .alusrca(alusrca1), .alusrcb(alusrcb1), .pcsrc(pcsrc1),
    .alu_control(aluControl1), .instr_done(instrDone1), .halted(halted1)
  );

  // {irwrite,pcen,iord,memwrite,regdst,memtoreg,regwrite,alusrca,
  //  alusrcb[1:0],pcsrc[1:0],alu_control[2:0],instr_done,halted}
  assign obs0 = {irwrite0, pcen0, iord0, memwrite0, regdst0, memtoreg0, regwrite0,
                 alusrca0, alusrcb0, pcsrc0, aluControl0, instrDone0, halted0};
  assign obs1 = {irwrite1, pcen1, iord1, memwrite1, regdst1, memtoreg1, regwrite1,
                 alusrca1, alusrcb1, pcsrc1, aluControl1, instrDone1, halted1};

  // Hand-written expected output table per state.
  function automatic logic [16:0] expOut(int s, logic [5:0] f, logic z);
    logic [2:0] fAlu;
    case (f)
      6'b100000: fAlu = 3'b010;
      6'b100010: fAlu = 3'b110;
      6'b100100: fAlu = 3'b000;
      6'b100101: fAlu = 3'b001;
      6'b101010: fAlu = 3'b111;
      default:   fAlu = 3'b010;
    endcase
    case (s)
      S_FETCH:   return {7'b1100000, 1'b0, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0};
      S_DECODE:  return {7'b0000000, 1'b0, 2'b11, 2'b00, 3'b010, 1'b0, 1'b0};
      S_MEMADR:  return {7'b0000000, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0};
      S_MEMRD:   return {7'b0010000, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0};
      S_MEMWB:   return {7'b0000011, 1'b0, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0};
      S_MEMWR:   return {7'b0011000, 1'b0, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0};
      S_EXECUTE: return {7'b0000000, 1'b1, 2'b00, 2'b00, fAlu,   1'b0, 1'b0};
      S_ALUWB:   return {7'b0000101, 1'b0, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0};
      S_BRANCH:  return {1'b0, z, 5'b00000, 1'b1, 2'b00, 2'b01, 3'b110, 1'b1, 1'b0};
      S_ADDIEX:  return {7'b0000000, 1'b1, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0};
      S_ADDIWB:  return {7'b0000001, 1'b0, 2'b00, 2'b00, 3'b010, 1'b1, 1'b0};
      S_JUMP:    return {7'b0100000, 1'b0, 2'b00, 2'b10, 3'b010, 1'b1, 1'b0};
      S_HALT:    return {7'b0000000, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0, 1'b1};
      default:   return 17'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset two edges; enables and halted must stay low throughout.
  task automatic test_reset();
    reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checkCount++;
      if ({irwrite0, pcen0, memwrite0, regwrite0, instrDone0, halted0} !== 6'b0) begin
        $display("[TB] FAIL reset_enables cycle %0d: got %b expected 000000", i,
                 {irwrite0, pcen0, memwrite0, regwrite0, instrDone0, halted0});
      end else passCount++;
    end
    reset = 1'b0;
    #1;
  endtask

  // lw: FETCH DECODE MEMADR MEMRD MEMWB, then back to FETCH.
  task automatic test_lw();
    int seq[6] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_FETCH};
    logic [16:0] exp;
    op = 6'b100011;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      exp = expOut(seq[i], funct, zero);
      checkCount++;
      if (obs0 !== exp) $display("[TB] FAIL lw cycle %0d: got %b expected %b", i + 1, obs0, exp);
      else passCount++;
    end
  endtask

  // R-type with sub, slt and an unknown funct (falls back to add).
  task automatic test_rtype();
    logic [5:0] fs[3] = '{6'b100010, 6'b101010, 6'b111111};
    int seq[4] = '{S_DECODE, S_EXECUTE, S_ALUWB, S_FETCH};
    logic [16:0] exp;
    op = 6'b000000;
    for (int k = 0; k < 3; k++) begin
      funct = fs[k];
      #1;
      for (int i = 0; i < 4; i++) begin
        step();
        exp = expOut(seq[i], funct, zero);
        checkCount++;
        if (obs0 !== exp)
          $display("[TB] FAIL rtype funct=%b cycle %0d: got %b expected %b", funct, i + 2, obs0, exp);
        else passCount++;
      end
    end
    funct = 6'b0;
  endtask

  // beq: zero=1 during DECODE must not load PC; BRANCH follows zero.
  task automatic test_beq();
    logic zs[2] = '{1'b1, 1'b0};
    int seq[3] = '{S_DECODE, S_BRANCH, S_FETCH};
    logic [16:0] exp;
    op = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        step();
        zero = (i == 0) ? 1'b1 : zs[k];
        #1;
        exp = expOut(seq[i], funct, zero);
        checkCount++;
        if (obs0 !== exp)
          $display("[TB] FAIL beq zero=%b cycle %0d: got %b expected %b", zs[k], i + 2, obs0, exp);
        else passCount++;
      end
    end
    zero = 1'b0;
    #1;
  endtask

  task automatic test_jump();
    int seq[3] = '{S_DECODE, S_JUMP, S_FETCH};
    logic [16:0] exp;
    op = 6'b000010;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = expOut(seq[i], funct, zero);
      checkCount++;
      if (obs0 !== exp) $display("[TB] FAIL jump cycle %0d: got %b expected %b", i + 2, obs0, exp);
      else passCount++;
    end
  endtask

  // sw immediately followed by addi.
  task automatic test_back_to_back();
    int seqSw[4]   = '{S_DECODE, S_MEMADR, S_MEMWR, S_FETCH};
    int seqAddi[4] = '{S_DECODE, S_ADDIEX, S_ADDIWB, S_FETCH};
    logic [16:0] exp;
    op = 6'b101011;
    #1;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = expOut(seqSw[i], funct, zero);
      checkCount++;
      if (obs0 !== exp) $display("[TB] FAIL sw cycle %0d: got %b expected %b", i + 2, obs0, exp);
      else passCount++;
    end
    op = 6'b001000;
    #1;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = expOut(seqAddi[i], funct, zero);
      checkCount++;
      if (obs0 !== exp) $display("[TB] FAIL addi cycle %0d: got %b expected %b", i + 2, obs0, exp);
      else passCount++;
    end
  endtask

  // Reset during MEMRD of lw: no writes, FETCH after the edge, clean restart.
  task automatic test_mid_reset();
    logic [16:0] exp;
    op = 6'b100011;
    #1;
    step(); step(); step();
    exp = expOut(S_MEMRD, funct, zero);
    checkCount++;
    if (obs0 !== exp) $display("[TB] FAIL midreset_memrd: got %b expected %b", obs0, exp);
    else passCount++;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      checkCount++;
      if ({irwrite0, pcen0, memwrite0, regwrite0, instrDone0} !== 5'b0)
        $display("[TB] FAIL midreset_enables %0d: got %b expected 00000", i,
                 {irwrite0, pcen0, memwrite0, regwrite0, instrDone0});
      else passCount++;
    end
    reset = 1'b0;
    op = 6'b000010;
    #1;
    exp = expOut(S_FETCH, funct, zero);
    checkCount++;
    if (obs0 !== exp) $display("[TB] FAIL midreset_fetch: got %b expected %b", obs0, exp);
    else passCount++;
    step();
    exp = expOut(S_DECODE, funct, zero);
    checkCount++;
    if (obs0 !== exp) $display("[TB] FAIL midreset_decode: got %b expected %b", obs0, exp);
    else passCount++;
    step(); step();
  endtask

  // Unknown opcode: dut0 refetches, dut1 halts until reset.
  task automatic test_illegal();
    logic [16:0] exp;
    op = 6'b111111;
    #1;
    step();
    exp = expOut(S_DECODE, funct, zero);
    checkCount++;
    if (obs1 !== exp) $display("[TB] FAIL illegal_decode: got %b expected %b", obs1, exp);
    else passCount++;
    step();
    exp = expOut(S_FETCH, funct, zero);
    checkCount++;
    if (obs0 !== exp) $display("[TB] FAIL illegal_notrap_fetch: got %b expected %b", obs0, exp);
    else passCount++;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      exp = expOut(S_HALT, funct, zero);
      checkCount++;
      if (obs1 !== exp) $display("[TB] FAIL illegal_halt cycle %0d: got %b expected %b", i, obs1, exp);
      else passCount++;
    end
    op = 6'b000000;
    step();
    checkCount++;
    if (halted1 !== 1'b1) $display("[TB] FAIL halt_sticky: got %b expected 1", halted1);
    else passCount++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    exp = expOut(S_FETCH, funct, zero);
    checkCount++;
    if (obs1 !== exp) $display("[TB] FAIL halt_cleared: got %b expected %b", obs1, exp);
    else passCount++;
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_jump();
    test_back_to_back();
    test_mid_reset();
    test_illegal();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
